shift_left_sequential: RTL

Multi-cycle logical left shifter with valid/ready handshakes on both sides, the left-shifting counterpart of the combinational right shifter in the ALU datapath. It gives the multi-cycle core a small, registered shift-left unit. The unit resolves one bit of the shift amount per clock, least-significant bit first, so an operation completes after a fixed log2(N) cycles. It holds the result until the consumer accepts it.

---
 rtl/shift_left_sequential.sv | 116 +++++++++++
 1 files changed

// File: rtl/shift_left_sequential.sv
// -----------------------------------------------------------------------------
// shift_left_sequential
//
// Multi-cycle logical left shifter with valid/ready handshakes on both sides.
// One bit of the shift amount is resolved per clock, least-significant bit
// first. Every operation therefore takes exactly S = $clog2(N) shift cycles,
// whatever the shift amount is. The result is held until the consumer takes it.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   i_valid  producer offers in/shamt
//   i_ready  unit is idle and can accept an operation
//   in       value to shift (N bits)
//   shamt    shift amount, 0..N-1 (S bits)
//   o_valid  result is present on out
//   o_ready  consumer accepts the result
//   out      in << shamt, zero-filled (meaningful only while o_valid = 1)
// -----------------------------------------------------------------------------
module shift_left_sequential #(
    parameter int N = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_valid,
    output logic                   i_ready,
    input  logic [N-1:0]           in,
    input  logic [$clog2(N)-1:0]   shamt,
    output logic                   o_valid,
    input  logic                   o_ready,
    output logic [N-1:0]           out
);

    localparam int S = $clog2(N);
    localparam logic [S-1:0] LAST_STAGE = S'(S - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t         state;
    logic [N-1:0]   data;
    logic [S-1:0]   amt;
    logic [S-1:0]   stage;

    // Apply the shift of weight 2**st when bit st of the amount is set.
    // The loop walks the stages so that the amount bit is selected with a
    // constant index instead of a variable-width one.
    function automatic logic [N-1:0] shift_stage(
        input logic [N-1:0] d,
        input logic [S-1:0] a,
        input logic [S-1:0] st
    );
        logic [N-1:0] r;
        r = d;
        for (int k = 0; k < S; k++) begin
            if (st == S'(k) && a[k]) begin
                r = d << (1 << k);
            end
        end
        return r;
    endfunction

    // i_ready and o_valid are kept as registers that change together with
    // state, so neither has a combinational path from any input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            data    <= '0;
            amt     <= '0;
            stage   <= '0;
            i_ready <= 1'b1;
            o_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        data    <= in;
                        amt     <= shamt;
                        stage   <= '0;
                        state   <= SHIFT;
                        i_ready <= 1'b0;
                        o_valid <= 1'b0;
                    end
                end
                SHIFT: begin
                    data  <= shift_stage(data, amt, stage);
                    stage <= stage + S'(1);
                    if (stage == LAST_STAGE) begin
                        state   <= DONE;
                        o_valid <= 1'b1;
                    end
                end
                DONE: begin
                    // data is not touched here, so out stays stable while
                    // the consumer stalls.
                    if (o_ready) begin
                        state   <= IDLE;
                        i_ready <= 1'b1;
                        o_valid <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    i_ready <= 1'b1;
                    o_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out = data;

endmodule
